// File: rtl/ime_pkg.sv
// ime_pkg: shared types and helpers for the IME egress stream transmitter.
//   IME_W_ACC / IME_W_LOG : default accumulator / score widths
//   TUSER_POISON_BIT      : tuser bit that carries poison on the output stream
//   ime_tx_entry_t        : one buffered beat {acc, score, tuser, last, poison}
//   eff_frame_len()       : frame length with 0 mapped to 1
package ime_pkg;

    localparam int IME_W_ACC        = 32;
    localparam int IME_W_LOG        = 16;
    localparam int TUSER_POISON_BIT = 7;

    typedef struct packed {
        logic [IME_W_ACC-1:0] acc;
        logic [IME_W_LOG-1:0] score;
        logic [7:0]           tuser;
        logic                 last;
        logic                 poison;
    } ime_tx_entry_t;

    localparam int IME_ENTRY_W = $bits(ime_tx_entry_t);

    function automatic logic [15:0] eff_frame_len(input logic [15:0] frame_len);
        return (frame_len == 16'd0) ? 16'd1 : frame_len;
    endfunction

endpackage

// File: rtl/ime_sync_fifo.sv
// ime_sync_fifo: generic single-clock FIFO, show-ahead read (rdata_o is the head).
//   clk_i, rst_ni      : clock, asynchronous active-low reset (pointers only)
//   push_i, wdata_i    : write request and data; ignored while full
//   pop_i, rdata_o     : read request and head entry; ignored while empty
//   full_o, empty_o    : occupancy flags
//   level_o            : current number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ime_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_LEVEL);
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    // Storage needs no reset: only entries behind the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ime_stream_tx.sv
// ime_stream_tx: egress AXI-Stream master for the IME pipeline.
// Buffers result beats, re-imposes frame boundaries from frame_len, propagates
// poison through the frame, and paces output beats with a constant idle gap.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_*                  : upstream beat (valid/ready, acc, score, tuser, last hint, poison)
//   m_axis_*              : AXI-Stream master, tdata = {acc, score}, tuser[7] = poison
//   frame_len             : beats per frame (0 behaves as 1)
//   const_time_cycles     : idle cycles forced after every output beat
//   frame_done            : pulse, cycle after the tlast handshake
//   frame_poisoned        : pulse with frame_done when the frame carried poison
//   len_mismatch          : pulse, cycle after a beat whose in_last disagreed with the count
//   fifo_level            : buffer occupancy
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high; once valid is raised, valid and payload hold until that transfer.
module ime_stream_tx
    import ime_pkg::*;
#(
    parameter int W_ACC      = IME_W_ACC,
    parameter int W_LOG      = IME_W_LOG,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W_ACC-1:0]             in_acc,
    input  logic [W_LOG-1:0]             in_score,
    input  logic [7:0]                   in_tuser,
    input  logic                         in_last,
    input  logic                         in_poison,
    output logic [W_ACC+W_LOG-1:0]       m_axis_tdata,
    output logic [7:0]                   m_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    input  logic [15:0]                  frame_len,
    input  logic [13:0]                  const_time_cycles,
    output logic                         frame_done,
    output logic                         frame_poisoned,
    output logic                         len_mismatch,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    ime_tx_entry_t in_entry;
    ime_tx_entry_t fifo_head;
    logic          fifo_full, fifo_empty, fifo_pop;

    // Output register: the beat currently presented on m_axis.
    ime_tx_entry_t out_entry_q, out_entry_d;
    logic          out_valid_q, out_valid_d;
    logic          out_mism_q, out_mism_d;

    logic [15:0]   cnt_q, cnt_d;
    logic [13:0]   gap_q, gap_d;
    logic          sticky_q, sticky_d;
    logic          done_q, done_d;
    logic          pois_q, pois_d;
    logic          mism_q, mism_d;

    logic          fire;
    logic [16:0]   cnt_inc;
    logic          reached;
    logic          head_tlast;

    always_comb begin
        in_entry        = '0;
        in_entry.acc    = in_acc;
        in_entry.score  = in_score;
        in_entry.tuser  = in_tuser;
        in_entry.last   = in_last;
        in_entry.poison = in_poison;
    end

    ime_sync_fifo #(
        .W     (IME_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (in_valid),
        .wdata_i (in_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Ready depends on occupancy only, never on the downstream tready.
    assign in_ready = !fifo_full;

    assign m_axis_tvalid = out_valid_q && (gap_q == '0);
    assign fire          = m_axis_tvalid && m_axis_tready;
    // Refill the register when empty or emptying this cycle; never overwrite an unfired beat.
    assign fifo_pop      = !fifo_empty && (!out_valid_q || fire);

    // Frame position of the head beat. A frame_len that shrank below the
    // current count also satisfies ">=" and forces the end of the frame.
    assign cnt_inc    = {1'b0, cnt_q} + 17'd1;
    assign reached    = (cnt_inc >= {1'b0, eff_frame_len(frame_len)});
    assign head_tlast = fifo_head.last | reached;

    always_comb begin
        out_entry_d = out_entry_q;
        out_valid_d = out_valid_q;
        out_mism_d  = out_mism_q;
        cnt_d       = cnt_q;
        if (fifo_pop) begin
            out_entry_d      = fifo_head;
            out_entry_d.last = head_tlast;
            out_valid_d      = 1'b1;
            out_mism_d       = (fifo_head.last != reached);
            cnt_d            = head_tlast ? 16'd0 : cnt_inc[15:0];
        end else if (fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        gap_d    = gap_q;
        if (fire) begin
            gap_d = const_time_cycles;
            if (out_entry_q.last)        sticky_d = 1'b0;
            else if (out_entry_q.poison) sticky_d = 1'b1;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 14'd1;
        end
        done_d = fire && out_entry_q.last;
        pois_d = fire && out_entry_q.last && (sticky_q || out_entry_q.poison);
        mism_d = fire && out_mism_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_entry_q <= '0;
            out_valid_q <= 1'b0;
            out_mism_q  <= 1'b0;
            cnt_q       <= '0;
            gap_q       <= '0;
            sticky_q    <= 1'b0;
            done_q      <= 1'b0;
            pois_q      <= 1'b0;
            mism_q      <= 1'b0;
        end else begin
            out_entry_q <= out_entry_d;
            out_valid_q <= out_valid_d;
            out_mism_q  <= out_mism_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            sticky_q    <= sticky_d;
            done_q      <= done_d;
            pois_q      <= pois_d;
            mism_q      <= mism_d;
        end
    end

    // Poison bit is live: beats already in the register pick up the frame
    // poison as soon as an earlier poisoned beat of the same frame fires.
    always_comb begin
        m_axis_tuser = out_entry_q.tuser;
        m_axis_tuser[TUSER_POISON_BIT] = out_entry_q.tuser[TUSER_POISON_BIT]
                                       | out_entry_q.poison | sticky_q;
    end

    assign m_axis_tdata   = {out_entry_q.acc, out_entry_q.score};
    assign m_axis_tlast   = out_entry_q.last;
    assign frame_done     = done_q;
    assign frame_poisoned = pois_q;
    assign len_mismatch   = mism_q;

endmodule

// File: tb/tb_ime_stream_tx.sv
module tb_ime_stream_tx;

    localparam int DW = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic [15:0] in_score = '0;
    logic [7:0]  in_tuser = '0;
    logic        in_last = 1'b0;
    logic        in_poison = 1'b0;
    logic [47:0] m_axis_tdata;
    logic [7:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [15:0] frame_len = 16'd4;
    logic [13:0] const_time_cycles = '0;
    logic        frame_done;
    logic        frame_poisoned;
    logic        len_mismatch;
    logic [2:0]  fifo_level;

    ime_stream_tx #(.W_ACC(32), .W_LOG(16), .FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_acc            (in_acc),
        .in_score          (in_score),
        .in_tuser          (in_tuser),
        .in_last           (in_last),
        .in_poison         (in_poison),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .frame_len         (frame_len),
        .const_time_cycles (const_time_cycles),
        .frame_done        (frame_done),
        .frame_poisoned    (frame_poisoned),
        .len_mismatch      (len_mismatch),
        .fifo_level        (fifo_level)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [DW-1:0] exp_q[$];
    int            n_fires, n_done, n_pois, n_pois_done, n_mism;
    logic [31:0]   last_mask, p7_mask;
    int            fire_edge[$];
    logic [7:0]    first_tuser;
    int            last_acc_edge;

    task automatic clear_logs();
        exp_q.delete();
        fire_edge.delete();
        n_fires = 0; n_done = 0; n_pois = 0; n_pois_done = 0; n_mism = 0;
        last_mask = '0; p7_mask = '0; first_tuser = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (n_fires == 0) first_tuser = m_axis_tuser;
                fire_edge.push_back(cyc + 1);
                if (exp_q.size() == 0) check_eq("unexpected_beat", 1, 0);
                else check_eq("beat_data", m_axis_tdata, exp_q.pop_front());
                if (n_fires < 32) begin
                    last_mask[n_fires] = m_axis_tlast;
                    p7_mask[n_fires]   = m_axis_tuser[7];
                end
                n_fires++;
            end
            if (frame_done) n_done++;
            if (frame_poisoned) n_pois++;
            if (frame_poisoned && frame_done) n_pois_done++;
            if (len_mismatch) n_mism++;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_beat(input logic [31:0] acc, input logic [15:0] score,
                             input logic [7:0] tuser, input logic last, input logic poison,
                             input int budget, output logic accepted);
        accepted  = 1'b0;
        in_valid  = 1'b1;
        in_acc    = acc;
        in_score  = score;
        in_tuser  = tuser;
        in_last   = last;
        in_poison = poison;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                exp_q.push_back({acc, score});
                last_acc_edge = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] acc, input logic last, input logic poison);
        logic ok;
        push_beat(acc, acc[15:0] ^ 16'hA500, 8'h05, last, poison, 50, ok);
        check_eq("push_accept", ok, 1);
    endtask

    task automatic wait_fires(input int n, input int budget);
        int k = 0;
        while (n_fires < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check_eq("fire_count", n_fires, n);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        check_eq("watchdog", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- tests ----------------
    initial begin
        int  acc_edge0;
        logic ok;
        clear_logs();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_tdata", m_axis_tdata, 0);
        check_eq("rst_tuser", m_axis_tuser, 0);
        check_eq("rst_tlast", m_axis_tlast, 0);
        check_eq("rst_flags", {frame_done, frame_poisoned, len_mismatch}, 0);
        check_eq("rst_level", fifo_level, 0);
        @(posedge clk);
        #1;

        // T1: frame_len=4, in_last on beats 4 and 8
        frame_len = 16'd4; const_time_cycles = '0; m_axis_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(32'h100 + i, (i % 4) == 0, 1'b0);
            if (i == 1) acc_edge0 = last_acc_edge;
        end
        wait_fires(8, 100);
        check_eq("t1_latency", fire_edge[0] - acc_edge0, 2);
        check_eq("t1_tlast", last_mask[7:0], 8'h88);
        check_eq("t1_done", n_done, 2);
        check_eq("t1_mism", n_mism, 0);

        // T2: frame_len=3, no in_last, 6 beats -> forced ends
        reset_dut();
        frame_len = 16'd3;
        for (int i = 1; i <= 6; i++) send(32'h200 + i, 1'b0, 1'b0);
        wait_fires(6, 100);
        check_eq("t2_tlast", last_mask[5:0], 6'h24);
        check_eq("t2_done", n_done, 2);
        check_eq("t2_mism", n_mism, 2);

        // T2b: frame_len=0 behaves as 1
        reset_dut();
        frame_len = 16'd0;
        for (int i = 1; i <= 3; i++) send(32'h280 + i, 1'b0, 1'b0);
        wait_fires(3, 100);
        check_eq("t2b_tlast", last_mask[2:0], 3'h7);
        check_eq("t2b_done", n_done, 3);
        check_eq("t2b_mism", n_mism, 3);

        // T3: C=5 pacing
        reset_dut();
        frame_len = 16'd4; const_time_cycles = 14'd5;
        for (int i = 1; i <= 4; i++) send(32'h300 + i, i == 4, 1'b0);
        wait_fires(4, 200);
        for (int i = 0; i < 3; i++)
            check_eq("t3_spacing", fire_edge[i+1] - fire_edge[i], 6);
        check_eq("t3_mism", n_mism, 0);
        const_time_cycles = '0;

        // T4: backpressure fills FIFO + register
        reset_dut();
        frame_len = 16'd16; m_axis_tready = 1'b0;
        for (int i = 1; i <= 5; i++) send(32'h400 + i, 1'b0, 1'b0);
        push_beat(32'h406, 16'h1234, 8'h05, 1'b0, 1'b0, 4, ok);
        check_eq("t4_beat6_blocked", ok, 0);
        @(negedge clk);
        check_eq("t4_in_ready", in_ready, 0);
        check_eq("t4_level", fifo_level, 4);
        check_eq("t4_tvalid", m_axis_tvalid, 1);
        check_eq("t4_tdata", m_axis_tdata, {32'h401, 16'h0401 ^ 16'hA500});
        repeat (4) @(negedge clk);
        check_eq("t4_tdata_hold", m_axis_tdata, {32'h401, 16'h0401 ^ 16'hA500});
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        wait_fires(5, 100);
        check_eq("t4_drained", exp_q.size(), 0);

        // T5: poison on beat 2 of a 4-beat frame, beat 5 starts a clean frame
        reset_dut();
        frame_len = 16'd4;
        for (int i = 1; i <= 5; i++) send(32'h500 + i, i == 4, i == 2);
        wait_fires(5, 100);
        check_eq("t5_tuser_beat1", first_tuser, 8'h05);
        check_eq("t5_poison_bits", p7_mask[4:0], 5'h0E);
        check_eq("t5_pois_with_done", n_pois_done, 1);
        check_eq("t5_pois", n_pois, 1);
        check_eq("t5_done", n_done, 1);

        // T6: reset mid-frame, then a fresh 4-beat frame
        reset_dut();
        frame_len = 16'd4;
        send(32'h601, 1'b0, 1'b0);
        send(32'h602, 1'b0, 1'b0);
        wait_fires(2, 100);
        m_axis_tready = 1'b0;
        send(32'h603, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_tvalid", m_axis_tvalid, 0);
        check_eq("t6_rst_tdata", m_axis_tdata, 0);
        check_eq("t6_rst_in_ready", in_ready, 1);
        check_eq("t6_rst_level", fifo_level, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'h610 + i, i == 4, 1'b0);
        wait_fires(4, 100);
        check_eq("t6_tlast", last_mask[3:0], 4'h8);
        check_eq("t6_mism", n_mism, 0);
        check_eq("t6_done", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
